pixel_sequencer: RTL and testbench
==================================

PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

Interface
REQ-001 Parameter ERASE_CYC, default 5: cycles ERASE is held high (1..65535).
REQ-002 Parameter EXPOSE_CYC, default 255: cycles EXPOSE is held high (1..65535).
REQ-003 Parameter DATA_W, default 8: ADC code width; conversion length is 2**DATA_W cycles.
REQ-004 CLK  in  1  sole clock; all state changes on rising edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 START  in  1  frame request, level-sampled in IDLE.
REQ-007 ERASE  out  1  pixel erase control to the array.
REQ-008 EXPOSE  out  1  pixel exposure control to the array.
REQ-009 READ  out  4  one-hot pixel read select; bit k drives READk of the array.
REQ-010 DATA_DRV  out  DATA_W  conversion counter value for the shared DATA bus.
REQ-011 DATA_OE  out  1  high = sequencer drives DATA bus with DATA_DRV; low = bus released.
REQ-012 DATA_IN  in  DATA_W  DATA bus sampled value.
REQ-013 PIX_DATA  out  DATA_W  captured pixel code.
REQ-014 PIX_IDX  out  2  index (0..3) of PIX_DATA.
REQ-015 PIX_VALID  out  1  PIX_DATA/PIX_IDX valid.
REQ-016 PIX_READY  in  1  downstream accepts when PIX_VALID and PIX_READY both high.
REQ-017 BUSY  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ERASE, EXPOSE, CONVERT, RD_SETTLE, RD_SAMPLE, RD_HOLD; all outputs registered (Moore).
REQ-019 IDLE: START=1 at an edge -> ERASE next cycle; START=0 -> stay.
REQ-020 ERASE: ERASE=1 for exactly ERASE_CYC cycles, then EXPOSE.
REQ-021 EXPOSE: EXPOSE=1 for exactly EXPOSE_CYC cycles, then CONVERT; ERASE and EXPOSE never high together.
REQ-022 CONVERT: DATA_OE=1; DATA_DRV=0 in first cycle, +1 each cycle, reaching 2**DATA_W-1 in cycle 2**DATA_W; no wrap; then RD_SETTLE with pixel index 0.
REQ-023 DATA_OE=0 in all states other than CONVERT; DATA_DRV=0 whenever DATA_OE=0.
REQ-024 RD_SETTLE: READ[idx]=1, DATA_OE=0, one cycle, then RD_SAMPLE.
REQ-025 RD_SAMPLE: READ[idx]=1; DATA_IN captured into PIX_DATA, idx into PIX_IDX at end of cycle; then RD_HOLD.
REQ-026 RD_HOLD: READ=0, PIX_VALID=1, PIX_DATA/PIX_IDX stable until handshake.
REQ-027 Handshake in RD_HOLD: idx<3 -> RD_SETTLE with idx+1; idx=3 -> IDLE; PIX_VALID low next cycle.
REQ-028 PIX_READY high before PIX_VALID has no effect; PIX_READY held high gives one pixel per 3 cycles.
REQ-029 START ignored while BUSY=1; START held high restarts a frame on the cycle after returning to IDLE (one IDLE cycle between frames).
REQ-030 READ at most one bit high; never high outside RD_SETTLE/RD_SAMPLE.

Reset
REQ-031 RST_N low asynchronously forces IDLE and all outputs to 0: ERASE, EXPOSE, READ, DATA_DRV, DATA_OE, PIX_DATA, PIX_IDX, PIX_VALID, BUSY.
REQ-032 Reset mid-frame aborts the frame; any pending pixel is discarded; after RST_N rises, a frame starts only on a new START sample.

Structure
REQ-033 Package pixel_seq_pkg holds the FSM state enum, DATA_W default and the ERASE/EXPOSE cycle-count defaults.
REQ-034 One sub-module, seq_counter: 16-bit loadable up-counter with terminal-count flag, shared by ERASE, EXPOSE and CONVERT phases.

Verification
REQ-035 ERASE_CYC=5, EXPOSE_CYC=10, START pulse 1 cycle -> ERASE high 5 cycles, EXPOSE high 10 cycles, DATA_DRV 0..255 over 256 cycles with DATA_OE=1.
REQ-036 PIX_READY tied 1, DATA_IN=8'h10+idx during RD_SAMPLE -> four outputs 0x10,0x11,0x12,0x13 with PIX_IDX 0..3, 3 cycles apart, then IDLE.
REQ-037 PIX_READY low 7 cycles on pixel 2 -> PIX_VALID, PIX_DATA, PIX_IDX=2 held stable 7 cycles, READ=0 throughout stall.
REQ-038 START pulsed during EXPOSE -> ignored; exactly one frame of 4 pixels produced.
REQ-039 RST_N low in CONVERT at DATA_DRV=100 -> all outputs 0 immediately, IDLE after release, no PIX_VALID until a new START.
REQ-040 START held high, PIX_READY=1 -> back-to-back frames, exactly one IDLE cycle between pixel 3 handshake and next ERASE.

Source files
------------

// File: rtl/pixel_seq_pkg.sv
// Shared types and defaults for the pixel array sequencer.
package pixel_seq_pkg;
  localparam int DATA_W_DEF     = 8;
  localparam int ERASE_CYC_DEF  = 5;
  localparam int EXPOSE_CYC_DEF = 255;
  localparam int CNT_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ERASE, ST_EXPOSE, ST_CONVERT, ST_RD_SETTLE, ST_RD_SAMPLE, ST_RD_HOLD
  } state_t;

  typedef struct packed {
    logic erase;
    logic expose;
    logic data_oe;
    logic pix_valid;
    logic busy;
  } ctrl_t;
endpackage

// File: rtl/seq_counter.sv
// 16-bit loadable up-counter; tc flags cnt == term. nxt exposes the D input so
// the owner can register outputs in step with the count.
module seq_counter import pixel_seq_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] nxt,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;

  always_comb begin
    nxt = cnt;
    if (load)    nxt = load_val;
    else if (en) nxt = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else        cnt <= nxt;

  assign tc = (cnt == term);
endmodule

// File: rtl/pixel_sequencer.sv
// Erase / expose / ramp-convert / read-out sequencer for a 4-pixel array.
// Outputs are registered from the next-state decode, so they are glitch-free Moore.
module pixel_sequencer import pixel_seq_pkg::*; #(
  parameter int ERASE_CYC  = ERASE_CYC_DEF,
  parameter int EXPOSE_CYC = EXPOSE_CYC_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              erase,
  output logic              expose,
  output logic [3:0]        read,
  output logic [DATA_W-1:0] data_drv,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] pix_data,
  output logic [1:0]        pix_idx,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy
);
  localparam logic [CNT_W-1:0] ERASE_TERM  = 16'(ERASE_CYC - 1);
  localparam logic [CNT_W-1:0] EXPOSE_TERM = 16'(EXPOSE_CYC - 1);
  localparam logic [CNT_W-1:0] CONV_TERM   = 16'((1 << DATA_W) - 1);

  state_t           st, st_nxt;
  logic [1:0]       idx, idx_nxt;
  logic             cnt_load, cnt_en, tc;
  logic [CNT_W-1:0] term, cnt_nxt;
  ctrl_t            ctrl, ctrl_nxt;
  logic [3:0]       read_nxt;
  logic [DATA_W-1:0] drv_nxt;

  seq_counter u_cnt (
    .clk(clk), .rst_n(rst_n), .load(cnt_load), .load_val('0),
    .en(cnt_en), .term(term), .nxt(cnt_nxt), .tc(tc)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st  <= ST_IDLE;
      idx <= '0;
    end else begin
      st  <= st_nxt;
      idx <= idx_nxt;
    end

  // Each timed phase restarts the shared counter from 0 on entry.
  always_comb begin
    st_nxt   = st;
    idx_nxt  = idx;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    term     = '0;
    case (st)
      ST_IDLE:
        if (start) begin st_nxt = ST_ERASE; cnt_load = 1'b1; end
      ST_ERASE: begin
        term = ERASE_TERM;
        if (tc) begin st_nxt = ST_EXPOSE; cnt_load = 1'b1; end
        else cnt_en = 1'b1;
      end
      ST_EXPOSE: begin
        term = EXPOSE_TERM;
        if (tc) begin st_nxt = ST_CONVERT; cnt_load = 1'b1; end
        else cnt_en = 1'b1;
      end
      ST_CONVERT: begin
        term = CONV_TERM;
        if (tc) begin st_nxt = ST_RD_SETTLE; idx_nxt = '0; end
        else cnt_en = 1'b1;
      end
      ST_RD_SETTLE: st_nxt = ST_RD_SAMPLE;
      ST_RD_SAMPLE: st_nxt = ST_RD_HOLD;
      ST_RD_HOLD:
        if (pix_ready) begin
          if (idx == 2'd3) st_nxt = ST_IDLE;
          else begin st_nxt = ST_RD_SETTLE; idx_nxt = idx + 2'd1; end
        end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_nxt.erase     = (st_nxt == ST_ERASE);
    ctrl_nxt.expose    = (st_nxt == ST_EXPOSE);
    ctrl_nxt.data_oe   = (st_nxt == ST_CONVERT);
    ctrl_nxt.pix_valid = (st_nxt == ST_RD_HOLD);
    ctrl_nxt.busy      = (st_nxt != ST_IDLE);
    read_nxt = '0;
    if (st_nxt == ST_RD_SETTLE || st_nxt == ST_RD_SAMPLE) read_nxt = 4'b0001 << idx_nxt;
    drv_nxt = (st_nxt == ST_CONVERT) ? DATA_W'(cnt_nxt) : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctrl     <= '0;
      read     <= '0;
      data_drv <= '0;
      pix_data <= '0;
      pix_idx  <= '0;
    end else begin
      ctrl     <= ctrl_nxt;
      read     <= read_nxt;
      data_drv <= drv_nxt;
      if (st == ST_RD_SAMPLE) begin
        pix_data <= data_in;
        pix_idx  <= idx;
      end
    end

  assign erase     = ctrl.erase;
  assign expose    = ctrl.expose;
  assign data_oe   = ctrl.data_oe;
  assign pix_valid = ctrl.pix_valid;
  assign busy      = ctrl.busy;
endmodule

// File: tb/tb_pixel_sequencer.sv
// Scoreboard bench: stimulus queues expected pixels, a monitor checks handshakes and phase timing.
module tb_pixel_sequencer;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n, start, pix_ready;
  logic          erase, expose, data_oe, pix_valid, busy;
  logic [3:0]    read;
  logic [DW-1:0] data_drv, data_in, pix_data, base;
  logic [1:0]    pix_idx;

  int checks = 0, errors = 0, cyc = 0;
  logic [9:0] exp_q[$];
  bit spacing_on;
  int last_hs;

  pixel_sequencer #(.ERASE_CYC(5), .EXPOSE_CYC(10), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .erase(erase), .expose(expose),
    .read(read), .data_drv(data_drv), .data_oe(data_oe), .data_in(data_in),
    .pix_data(pix_data), .pix_idx(pix_idx), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Array model: selected pixel presents base + index on the bus.
  always_comb begin
    data_in = '0;
    for (int k = 0; k < 4; k++) if (read[k]) data_in = base + DW'(k);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++; errors++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
  endtask

  task automatic tick(); @(negedge clk); endtask

  task automatic push_frame(input logic [DW-1:0] b);
    for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), b + DW'(i)});
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
    chk("start_latency_erase", int'(erase), 1);
    chk("start_latency_busy", int'(busy), 1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    if (n >= 2000) timeout(nm);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_erase"}, int'(erase), 0);     chk({nm, "_expose"}, int'(expose), 0);
    chk({nm, "_read"}, int'(read), 0);       chk({nm, "_data_drv"}, int'(data_drv), 0);
    chk({nm, "_data_oe"}, int'(data_oe), 0); chk({nm, "_pix_data"}, int'(pix_data), 0);
    chk({nm, "_pix_idx"}, int'(pix_idx), 0); chk({nm, "_pix_valid"}, int'(pix_valid), 0);
    chk({nm, "_busy"}, int'(busy), 0);
  endtask

  // Monitor: samples 1 time unit after the falling edge, once stimulus has settled.
  initial begin
    int er_run = 0, ex_run = 0, cv_run = 0;
    logic [9:0] e;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        er_run = 0; ex_run = 0; cv_run = 0;
      end else begin
        chk("erase_expose_excl", int'(erase & expose), 0);
        chk("read_onehot0", int'($onehot0(read)), 1);
        if (erase) er_run++;
        else if (er_run != 0) begin chk("erase_len", er_run, 5); er_run = 0; end
        if (expose) ex_run++;
        else if (ex_run != 0) begin chk("expose_len", ex_run, 10); ex_run = 0; end
        if (data_oe) begin
          chk("data_drv_ramp", int'(data_drv), cv_run); cv_run++;
        end else begin
          chk("data_drv_released", int'(data_drv), 0);
          if (cv_run != 0) begin chk("convert_len", cv_run, 256); cv_run = 0; end
        end
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) timeout("unexpected_pixel");
          else begin
            e = exp_q.pop_front();
            chk("pix_data", int'(pix_data), int'(e[7:0]));
            chk("pix_idx", int'(pix_idx), int'(e[9:8]));
          end
          if (spacing_on && pix_idx != 2'd0) chk("pix_spacing", cyc - last_hs, 3);
          last_hs = cyc;
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; pix_ready = 1'b1; base = '0; spacing_on = 1'b1;
    repeat (3) tick();
    #1 chk_all_zero("reset");
    tick(); rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_after_reset_busy", int'(busy), 0);

    // Nominal frame, ready tied high: 0x10..0x13, 3 cycles apart.
    base = 8'h10; push_frame(8'h10);
    pulse_start();
    wait_idle("t1_frame");
    chk("t1_queue_empty", exp_q.size(), 0);

    // Downstream stall of 7 cycles on pixel 2.
    base = 8'h40; push_frame(8'h40); spacing_on = 1'b0;
    pulse_start();
    n = 0;
    while (!read[2] && n < 600) begin tick(); n++; end
    if (n >= 600) timeout("t2_wait_read2");
    pix_ready = 1'b0;
    n = 0;
    while (!pix_valid && n < 10) begin tick(); n++; end
    if (n >= 10) timeout("t2_wait_valid");
    for (int s = 0; s < 7; s++) begin
      chk("stall_valid", int'(pix_valid), 1);
      chk("stall_data", int'(pix_data), 8'h42);
      chk("stall_idx", int'(pix_idx), 2);
      chk("stall_read", int'(read), 0);
      tick();
    end
    pix_ready = 1'b1;
    wait_idle("t2_frame");
    chk("t2_queue_empty", exp_q.size(), 0);
    spacing_on = 1'b1;

    // START during EXPOSE is ignored: one frame only.
    base = 8'h70; push_frame(8'h70);
    pulse_start();
    n = 0;
    while (!expose && n < 30) begin tick(); n++; end
    if (n >= 30) timeout("t3_wait_expose");
    start = 1'b1; tick(); start = 1'b0;
    wait_idle("t3_frame");
    for (int s = 0; s < 20; s++) begin chk("t3_no_second_frame", int'(busy), 0); tick(); end
    chk("t3_queue_empty", exp_q.size(), 0);

    // Reset in CONVERT at DATA_DRV=100 aborts the frame.
    base = 8'h90; push_frame(8'h90);
    pulse_start();
    n = 0;
    while (!(data_oe && data_drv == 8'd100) && n < 400) begin tick(); n++; end
    if (n >= 400) timeout("t4_wait_drv100");
    rst_n = 1'b0;
    #1 chk_all_zero("midframe_reset");
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int s = 0; s < 300; s++) begin
      tick();
      chk("t4_no_valid", int'(pix_valid), 0);
      chk("t4_idle", int'(busy), 0);
    end
    base = 8'hB0; push_frame(8'hB0);
    pulse_start();
    wait_idle("t4_new_frame");
    chk("t4_queue_empty", exp_q.size(), 0);

    // START held: back-to-back frames with a single IDLE cycle between.
    base = 8'hC0; push_frame(8'hC0); push_frame(8'hC0);
    start = 1'b1;
    for (int f = 0; f < 2; f++) begin
      n = 0;
      while (!(pix_valid && pix_ready && pix_idx == 2'd3) && n < 1000) begin tick(); n++; end
      if (n >= 1000) timeout("t5_wait_last_pixel");
      if (f == 0) begin
        tick();
        chk("t5_gap_idle", int'(busy), 0);
        tick();
        chk("t5_restart_erase", int'(erase), 1);
      end else start = 1'b0;
    end
    tick();
    wait_idle("t5_frames");
    repeat (3) tick();
    chk("t5_stays_idle", int'(busy), 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
